// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants, state type and tile-address helper for the frame-buffer arbiter.
package vga_fb_pkg;

    localparam int unsigned H_TILES    = 80;
    localparam int unsigned V_TILES    = 60;
    localparam int unsigned TILE_SHIFT = 3;
    localparam int unsigned FB_DEPTH   = H_TILES * V_TILES;
    localparam int unsigned FB_ADDR_W  = 13;
    localparam int unsigned PIX_W      = 10;
    localparam int unsigned COLOR_W    = 3;

    typedef enum logic {
        IDLE,
        CLEAR
    } fb_state_t;

    // Row-major tile index, computed one bit wider than the RAM address
    function automatic logic [FB_ADDR_W:0] tile_addr(input logic [PIX_W-1:0] x,
                                                     input logic [PIX_W-1:0] y);
        logic [FB_ADDR_W:0] row;
        logic [FB_ADDR_W:0] col;
        row = (FB_ADDR_W+1)'(y >> TILE_SHIFT);
        col = (FB_ADDR_W+1)'(x >> TILE_SHIFT);
        return row * (FB_ADDR_W+1)'(H_TILES) + col;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host write port of the frame-buffer arbiter: request held until acknowledged.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [2:0]        host_data;
    logic              host_ack;

    modport master (output host_req, host_addr, host_data, input host_ack);
    modport slave  (input host_req, host_addr, host_data, output host_ack);
endinterface

// File: rtl/vga_fb_arbiter_scan_pipe.sv
// Display read pipeline: turns RAM read data into rgb, two clocks behind the scan
// position, with hsync/vsync delayed to match.
module fb_scan_pipe
    import vga_fb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync_out,
    output logic               vsync_out
);

    logic rd_d1;
    logic blank_d1;
    logic hs_d1;
    logic vs_d1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d1     <= 1'b0;
            blank_d1  <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rd_d1     <= p_tick & video_on;
            blank_d1  <= p_tick & ~video_on;
            hs_d1     <= hsync_in;
            vs_d1     <= vsync_in;
            hsync_out <= hs_d1;
            vsync_out <= vs_d1;
            // RAM data is valid the clock after the read was issued
            if (rd_d1) begin
                rgb <= mem_rdata;
            end else if (blank_d1) begin
                rgb <= '0;
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: scan-out reads own pixel-tick slots; host writes and the
// clear engine share the remaining cycles of the single-port RAM.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_W           = FB_ADDR_W,
    parameter bit          BLANK_WRITE_ONLY = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic [PIX_W-1:0]   pixel_x,
    input  logic [PIX_W-1:0]   pixel_y,
    input  logic               hsync_in,
    input  logic               vsync_in,
    vga_fb_arbiter_if.slave    host,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               busy,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync_out,
    output logic               vsync_out
);

    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    fb_state_t          state, state_nxt;
    logic [ADDR_W-1:0]  clr_cnt, clr_cnt_nxt;
    logic [COLOR_W-1:0] clr_color, clr_color_nxt;
    logic               ack_d1;
    logic               display_slot;
    logic               free_slot;
    logic               host_in_range;

    assign display_slot  = p_tick & video_on;
    assign free_slot     = BLANK_WRITE_ONLY ? ~video_on : ~display_slot;
    assign host_in_range = (ADDR_W+1)'(host.host_addr) < DEPTH;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            clr_color <= '0;
            busy      <= 1'b0;
            ack_d1    <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            clr_color <= clr_color_nxt;
            busy      <= (state_nxt == CLEAR);
            ack_d1    <= host.host_ack;
        end
    end

    // RAM port driven combinationally: the RAM registers the address itself
    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        clr_color_nxt = clr_color;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        host.host_ack = 1'b0;
        if (!reset) begin
            if (display_slot) begin
                mem_addr = ADDR_W'(tile_addr(pixel_x, pixel_y));
            end
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state_nxt     = CLEAR;
                        clr_cnt_nxt   = '0;
                        clr_color_nxt = clear_color;
                    end else if (host.host_req && free_slot && !ack_d1) begin
                        host.host_ack = 1'b1;
                        if (host_in_range) begin
                            mem_we    = 1'b1;
                            mem_addr  = host.host_addr;
                            mem_wdata = host.host_data;
                        end
                    end
                end
                CLEAR: begin
                    if (free_slot) begin
                        mem_we      = 1'b1;
                        mem_addr    = clr_cnt;
                        mem_wdata   = clr_color;
                        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                        if (clr_cnt == LAST_ADDR) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    fb_scan_pipe u_scan_pipe (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .mem_rdata (mem_rdata),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM (3-bit colour per tile) between VGA scan-out and a host write port.
- The scan-out has priority on pixel ticks. Host writes and a hardware clear engine use the remaining free cycles.
- Sits between vga_sync and the top-level rgb/hsync/vsync pins. It replaces the direct switch-to-rgb path with tile-based video.

Parameters:
- H_TILES, 80, tiles per line (640/8)
- V_TILES, 60, tiles per frame (480/8)
- TILE_SHIFT, 3, log2 of tile edge in pixels
- ADDR_W, 13, frame-buffer address width (must satisfy 2^ADDR_W >= H_TILES*V_TILES)
- BLANK_WRITE_ONLY, 0, 1 = host and clear writes are allowed only while video_on=0

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- p_tick  in  1  pixel tick from vga_sync, one clk in two
- video_on  in  1  active-region flag from vga_sync
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- hsync_in  in  1  from vga_sync
- vsync_in  in  1  from vga_sync
- host_req  in  1  write request, held until host_ack
- host_addr  in  ADDR_W  tile address
- host_data  in  3  tile colour
- host_ack  out  1  one-clk pulse, request consumed
- clear_req  in  1  pulse, starts a full-buffer clear
- clear_color  in  3  fill colour, sampled when clear starts
- busy  out  1  clear in progress
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  3  RAM write data
- mem_rdata  in  3  RAM read data, valid one clk after address
- rgb  out  3  pixel colour
- hsync_out  out  1  hsync_in delayed 2 clk
- vsync_out  out  1  vsync_in delayed 2 clk

Behaviour:
- Reset values:
  - Outputs: rgb=0, host_ack=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, hsync_out=0, vsync_out=0.
  - Internal state: FSM to IDLE, clear counter to 0, pipeline flags to 0.
  - Reset mid-clear aborts the clear. Buffer contents are left partially cleared.
- Display slot:
  - A display slot is a cycle with p_tick=1 and video_on=1.
  - In that slot, drive mem_addr = (pixel_y>>TILE_SHIFT)*H_TILES + (pixel_x>>TILE_SHIFT), with mem_we=0.
  - Display always wins the slot.
- Display pipeline:
  - Cycle t: issue the read and set rd_d1 = 1.
  - Cycle t+1: rgb <= mem_rdata.
  - A p_tick with video_on=0 sets blank_d1. The next clk then forces rgb <= 0.
  - Otherwise rgb holds its value.
  - Latency is 2 clk, matching the hsync/vsync delay.
- Free cycle: any non-display cycle. When BLANK_WRITE_ONLY=1, only cycles with video_on=0 count as free.
- FSM IDLE:
  - clear_req=1 → go to CLEAR, latch clear_color, counter=0, busy=1 from the next clk.
  - clear_req has priority over a simultaneous host_req.
  - Otherwise, when host_req=1 and the cycle is free:
    - If host_addr < H_TILES*V_TILES: drive mem_addr=host_addr, mem_wdata=host_data, mem_we=1.
    - Out-of-range address: mem_we=0.
    - In both cases assert host_ack in the same clk.
- FSM CLEAR:
  - Each free cycle writes latched colour at address counter, then counter++.
  - The write to the last address H_TILES*V_TILES-1 returns the FSM to IDLE, with busy=0 the next clk.
  - host_req is not acked during CLEAR; the host waits.
  - clear_req during CLEAR is ignored.
- host_ack never asserts in two consecutive clk for the same held request. The host must drop or change host_req after ack.
- Address arithmetic is done in ADDR_W+1 bits. Tile coordinates beyond H_TILES/V_TILES cannot occur while video_on=1.

Decomposition:
- Package vga_fb_pkg:
  - Constants: H_TILES, V_TILES, TILE_SHIFT, FB_DEPTH = H_TILES*V_TILES.
  - Enum fb_state_t {IDLE, CLEAR}.
  - Function tile_addr(x, y).
- Sub-module fb_scan_pipe: display read-issue flag, 2-stage rgb/blank pipeline and hsync/vsync delay.
- Arbitration FSM and clear counter live in the top.

Test Plan:
1. Reset asserted mid-frame → all outputs 0 on the same edge; release → the first display slot at x=0,y=0 drives mem_addr=0.
2. Preload tile 81 = 3'b101; scan pixel_x=8, pixel_y=8 with video_on=1 → mem_addr=81 on the p_tick clk, and rgb=101 two clk later. With video_on=0 → rgb=000.
3. host_req with addr=4799, data=3'b110, held across a display slot → no ack in the p_tick clk. In the next free clk: mem_we=1, mem_addr=4799, host_ack=1 for exactly one clk.
4. host_req with addr=4800 → host_ack pulses and mem_we stays 0.
5. clear_req, clear_color=3'b010, with a concurrent host_req → busy=1. Exactly 4800 writes of 010 at addresses 0..4799 with no gaps except display slots. Then busy=0, and the host write is acked on the following free clk.
6. BLANK_WRITE_ONLY=1 → host_req during video_on=1 waits. Ack occurs on the first clk with video_on=0.
